// File: rtl/si571_pll_loop_filter.sv
// Digital PI loop filter for the Si571 flip-flop phase detector. It turns the
// up/down pump requests into a VCXO tuning word, a sigma-delta tune bit and a lock flag.
module si571_pll_loop_filter #(
   parameter int WIN_LOG2 = 10,
   parameter int OUT_W    = 16,
   parameter int KP_SHIFT = 4,
   parameter int KI_SHIFT = 8,
   parameter int LOCK_TH  = 8,
   parameter int LOCK_WIN = 16
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       pll_cfg_en,
   input  logic                       pll_hi_i,
   input  logic                       pll_lo_i,
   output logic [OUT_W-1:0]           tune_o,
   output logic                       tune_valid_o,
   output logic                       sd_o,
   output logic                       locked_o,
   output logic signed [WIN_LOG2+1:0] err_o
);

   localparam int EW    = WIN_LOG2 + 2;
   localparam int CNT_W = WIN_LOG2 + 1;
   localparam int IW    = OUT_W + KI_SHIFT + 1;
   localparam int PW    = EW + KP_SHIFT;
   localparam int CW    = ((IW > PW) ? IW : PW) + 2;
   localparam int LC_W  = $clog2(LOCK_WIN + 1);

   localparam longint INTEG_LIM = longint'(1) << (OUT_W - 1 + KI_SHIFT);
   localparam logic signed [IW:0]   SUM_HI    = (IW+1)'(INTEG_LIM);
   localparam logic signed [IW:0]   SUM_LO    = (IW+1)'(-INTEG_LIM);
   localparam logic signed [IW-1:0] INTEG_MAX = IW'(INTEG_LIM);
   localparam logic signed [IW-1:0] INTEG_MIN = IW'(-INTEG_LIM);
   localparam logic [OUT_W-1:0]     MID       = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic signed [CW-1:0] MID_EXT   = {{(CW-OUT_W){1'b0}}, MID};
   localparam logic signed [CW-1:0] TUNE_MAX  = {{(CW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
   localparam logic [EW-1:0]        LOCK_TH_V = EW'(LOCK_TH);
   localparam logic [LC_W-1:0]      LOCK_WIN_V = LC_W'(LOCK_WIN);

   logic                    active;
   logic [1:0]              hi_sync;
   logic [1:0]              lo_sync;
   logic                    up;
   logic                    dn;
   logic                    run_q;
   logic [WIN_LOG2-1:0]     win_cnt;
   logic [CNT_W-1:0]        up_cnt;
   logic [CNT_W-1:0]        dn_cnt;
   logic [CNT_W-1:0]        up_tot;
   logic [CNT_W-1:0]        dn_tot;
   logic signed [EW-1:0]    err_win;
   logic signed [EW-1:0]    err_r;
   logic                    err_stb;
   logic signed [IW-1:0]    integ;
   logic signed [IW:0]      integ_sum;
   logic signed [IW-1:0]    integ_next;
   logic signed [CW-1:0]    i_ext;
   logic signed [CW-1:0]    p_ext;
   logic signed [CW-1:0]    ctrl_next;
   logic signed [CW-1:0]    ctrl_r;
   logic                    integ_stb;
   logic signed [CW-1:0]    tune_sum;
   logic [OUT_W-1:0]        tune_sat;
   logic [EW-1:0]           err_abs;
   logic [LC_W-1:0]         lock_cnt;
   logic [LC_W-1:0]         lc_next;
   logic [OUT_W:0]          sd_acc;

   // Disable behaves like reset for the whole loop; only the sigma-delta keeps running.
   assign active = rstn_i & pll_cfg_en;

   // Idle detector levels (hi=1, lo=0) are the reset values so no phantom pulses appear.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         hi_sync <= 2'b11;
         lo_sync <= 2'b00;
      end else begin
         hi_sync <= {hi_sync[0], pll_hi_i};
         lo_sync <= {lo_sync[0], pll_lo_i};
      end
   end

   assign up      = ~hi_sync[1];
   assign dn      = lo_sync[1];
   assign up_tot  = up_cnt + {{(CNT_W-1){1'b0}}, up};
   assign dn_tot  = dn_cnt + {{(CNT_W-1){1'b0}}, dn};
   assign err_win = $signed({1'b0, up_tot}) - $signed({1'b0, dn_tot});
   assign err_o   = err_r;

   // run_q delays the first window by one cycle so it begins after enable is seen high.
   always_ff @(posedge clk_i) begin
      if (!active) begin
         run_q   <= 1'b0;
         win_cnt <= '0;
         up_cnt  <= '0;
         dn_cnt  <= '0;
         err_r   <= '0;
         err_stb <= 1'b0;
      end else begin
         run_q   <= 1'b1;
         err_stb <= 1'b0;
         if (run_q) begin
            if (win_cnt == '1) begin
               win_cnt <= '0;
               up_cnt  <= '0;
               dn_cnt  <= '0;
               err_r   <= err_win;
               err_stb <= 1'b1;
            end else begin
               win_cnt <= win_cnt + 1'b1;
               up_cnt  <= up_tot;
               dn_cnt  <= dn_tot;
            end
         end
      end
   end

   always_comb begin
      integ_sum = {integ[IW-1], integ} + {{(IW+1-EW){err_r[EW-1]}}, err_r};
      if (integ_sum > SUM_HI) begin
         integ_next = INTEG_MAX;
      end else if (integ_sum < SUM_LO) begin
         integ_next = INTEG_MIN;
      end else begin
         integ_next = integ_sum[IW-1:0];
      end
      i_ext     = {{(CW-IW){integ_next[IW-1]}}, integ_next};
      p_ext     = {{(CW-EW){err_r[EW-1]}}, err_r};
      ctrl_next = (i_ext >>> KI_SHIFT) + (p_ext <<< KP_SHIFT);
   end

   always_ff @(posedge clk_i) begin
      if (!active) begin
         integ     <= '0;
         ctrl_r    <= '0;
         integ_stb <= 1'b0;
      end else begin
         integ_stb <= err_stb;
         if (err_stb) begin
            integ  <= integ_next;
            ctrl_r <= ctrl_next;
         end
      end
   end

   always_comb begin
      tune_sum = MID_EXT + ctrl_r;
      if (tune_sum[CW-1]) begin
         tune_sat = '0;
      end else if (tune_sum > TUNE_MAX) begin
         tune_sat = '1;
      end else begin
         tune_sat = tune_sum[OUT_W-1:0];
      end
      err_abs = err_r[EW-1] ? -err_r : err_r;
      if (err_abs <= LOCK_TH_V) begin
         lc_next = (lock_cnt == LOCK_WIN_V) ? lock_cnt : lock_cnt + 1'b1;
      end else begin
         lc_next = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!active) begin
         tune_o       <= MID;
         tune_valid_o <= 1'b0;
         lock_cnt     <= '0;
         locked_o     <= 1'b0;
      end else begin
         tune_valid_o <= integ_stb;
         if (integ_stb) begin
            tune_o   <= tune_sat;
            lock_cnt <= lc_next;
            locked_o <= (lc_next == LOCK_WIN_V);
         end
      end
   end

   // First-order modulator: the carry out of the accumulator is the density-coded tune bit.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         sd_acc <= '0;
         sd_o   <= 1'b0;
      end else begin
         sd_acc <= {1'b0, sd_acc[OUT_W-1:0]} + {1'b0, tune_o};
         sd_o   <= sd_acc[OUT_W];
      end
   end

endmodule
